// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: fetch FSM states, instruction width, NOP word, PC step.
// No logic; imported by fetch_stage and the pipeline registers.
package pipeline_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with write-enable, flush and bubble insertion (NOP, valid=0, pc4 held).
// Latency: one cycle from inputs to outputs.
// Backpressure: write_en=0 holds contents; flush overrides write_en.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int                 PC_WIDTH  = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_en,
    input  logic                flush,
    input  logic                bubble,
    input  logic [PC_WIDTH-1:0] pc4_in,
    input  logic [INSTR_W-1:0]  instr_in,
    output logic [PC_WIDTH-1:0] pc4,
    output logic [INSTR_W-1:0]  instr,
    output logic                valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4   <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (write_en) begin
            if (bubble) begin
                instr <= NOP_INSTR;
                valid <= 1'b0;
            end else begin
                pc4   <= pc4_in;
                instr <= instr_in;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack handshake, IF/ID register; FETCH_PERF_CNT_EN adds bubble/kill counters.
// Latency: zero-wait ack lands in IF/ID at the next edge; slow memory inserts bubbles (fetch_busy).
// Backpressure: if_id_write=0 parks an acked word in a one-entry holding buffer with imem_req low.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_write,
    input  logic                if_id_write,
    input  logic                if_id_flush,
    input  logic                pc_source,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [PC_WIDTH-1:0] if_id_pc4,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic                if_id_valid,
    output logic                fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         bubble_cnt,
    output logic [31:0]         kill_cnt
`endif
);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] saved_target;
    logic [INSTR_W-1:0]  hold_buf;
    logic                kill;

    logic                redirect;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                in_fetch;
    logic                in_hold;
    logic                ack_taken;
    logic                usable;
    logic                discard;
    logic                word_avail;
    logic                latency_bubble;

    always_comb begin
        redirect       = pc_write & (pc_source | jump);
        target         = pc_source ? branch_target : jump_target;
        pc_plus4       = pc + PC_WIDTH'(PC_INC);
        in_fetch       = (state == S_FETCH);
        in_hold        = (state == S_HOLD);
        ack_taken      = in_fetch & imem_ack;
        usable         = ack_taken & ~kill & ~redirect;
        discard        = ack_taken & (kill | redirect);
        word_avail     = usable | (in_hold & ~redirect);
        latency_bubble = in_fetch & if_id_write & ~if_id_flush & ~usable;
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            kill         <= 1'b0;
            saved_target <= '0;
            hold_buf     <= NOP_INSTR;
            fetch_busy   <= 1'b0;
        end else begin
            fetch_busy <= latency_bubble;
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (ack_taken) begin
                        kill <= 1'b0;
                        if (redirect) begin
                            pc <= target;
                        end else if (kill) begin
                            pc <= saved_target;
                        end else if (if_id_write && !if_id_flush) begin
                            if (pc_write) pc <= pc_plus4;
                        end else begin
                            // Decode not ready (or flushing without redirect): park the word.
                            hold_buf <= imem_rdata;
                            state    <= S_HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Address must stay stable until the outstanding ack; retarget afterwards.
                        kill         <= 1'b1;
                        saved_target <= target;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc       <= target;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end else if (if_id_write && !if_id_flush) begin
                        if (pc_write) pc <= pc_plus4;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .PC_WIDTH  (PC_WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .write_en (if_id_write),
        .flush    (if_id_flush),
        .bubble   (~word_avail),
        .pc4_in   (pc_plus4),
        .instr_in (in_hold ? hold_buf : imem_rdata),
        .pc4      (if_id_pc4),
        .instr    (if_id_instr),
        .valid    (if_id_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            kill_cnt   <= '0;
        end else begin
            if (fetch_busy && bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
            if (discard && kill_cnt != 32'hFFFF_FFFF) kill_cnt <= kill_cnt + 32'd1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, then randomized run against a queue-based model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, if_id_write, if_id_flush, pc_source, jump;
    logic [31:0] branch_target, jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc4, if_id_instr;
    logic        if_id_valid, fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt, kill_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .pc_source     (pc_source),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_busy    (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .bubble_cnt    (bubble_cnt),
        .kill_cnt      (kill_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic pw, iw, fl, ps, jp;
        logic [31:0] br, jt;
        logic ack;
        logic [31:0] rdata;
        logic e_req;
        logic [31:0] e_addr, e_pc4, e_instr;
        logic e_valid, e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic pw, iw, fl, ps, jp, input logic [31:0] br, jt,
                       input logic ack, input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_addr, e_pc4, e_instr,
                       input logic e_valid, e_busy);
        vec_t v;
        v.pw = pw; v.iw = iw; v.fl = fl; v.ps = ps; v.jp = jp;
        v.br = br; v.jt = jt; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc4 = e_pc4; v.e_instr = e_instr;
        v.e_valid = e_valid; v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic [31:0] e_pc4, input logic [31:0] e_instr,
                             input logic e_valid, input logic e_busy);
        check({tag, ".imem_req"},    {31'b0, imem_req},    {31'b0, e_req});
        check({tag, ".imem_addr"},   imem_addr,            e_addr);
        check({tag, ".if_id_pc4"},   if_id_pc4,            e_pc4);
        check({tag, ".if_id_instr"}, if_id_instr,          e_instr);
        check({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
        check({tag, ".fetch_busy"},  {31'b0, fetch_busy},  {31'b0, e_busy});
    endtask

    task automatic drive(input logic pw, iw, fl, ps, jp, input logic [31:0] br, jt,
                         input logic ack, input logic [31:0] rdata);
        pc_write = pw; if_id_write = iw; if_id_flush = fl; pc_source = ps; jump = jp;
        branch_target = br; jump_target = jt; imem_ack = ack; imem_rdata = rdata;
    endtask

    // ---------------- reference model ----------------
    logic        m_warm;
    logic [31:0] m_pc;
    logic [31:0] m_held[$];
    logic [31:0] m_pend[$];
    logic [31:0] e_pc4, e_instr;
    logic        e_valid, e_busy;
    int unsigned m_bub, m_kill;

    function automatic logic m_req();
        return !m_warm && (m_held.size() == 0);
    endfunction

    task automatic model_reset();
        m_warm = 1'b1; m_pc = 32'h0; m_held.delete(); m_pend.delete();
        e_pc4 = 32'h0; e_instr = 32'h0; e_valid = 1'b0; e_busy = 1'b0;
        m_bub = 0; m_kill = 0;
    endtask

    task automatic model_step(input logic pw, iw, fl, ps, jp, input logic [31:0] br, jt,
                              input logic ack, input logic [31:0] rdata);
        logic redir, got;
        logic [31:0] tgt, old_pc, word;
        redir = pw && (ps || jp);
        tgt = ps ? br : jt;
        old_pc = m_pc;
        got = 1'b0;
        word = rdata;
        if (e_busy) m_bub++;
        e_busy = 1'b0;
        if (m_warm) begin
            m_warm = 1'b0;
        end else if (m_held.size() > 0) begin
            if (redir) begin
                m_held.delete();
                m_pc = tgt;
            end else if (!fl && iw) begin
                got = 1'b1;
                word = m_held.pop_front();
                if (pw) m_pc = old_pc + 32'd4;
            end
        end else begin
            if (ack && (m_pend.size() > 0 || redir)) begin
                m_kill++;
                m_pc = redir ? tgt : m_pend[0];
                m_pend.delete();
            end else if (ack) begin
                if (!fl && iw) begin
                    got = 1'b1;
                    if (pw) m_pc = old_pc + 32'd4;
                end else begin
                    m_held.push_back(rdata);
                end
            end else if (redir) begin
                m_pend.delete();
                m_pend.push_back(tgt);
            end
            e_busy = !fl && iw && !got;
        end
        if (fl) begin
            e_instr = 32'h0; e_valid = 1'b0;
        end else if (iw) begin
            if (got) begin
                e_pc4 = old_pc + 32'd4; e_instr = word; e_valid = 1'b1;
            end else begin
                e_instr = 32'h0; e_valid = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    initial begin
        int mem_wait;
        logic pw, iw, fl, ps, jp, ack;
        logic [31:0] br, jt, rd;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_all("reset", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b1;

        //  pw iw fl ps jp  br           jt           ack rdata          req addr          pc4           instr         vld busy
        add(1, 1, 0, 0, 0, 0,           0,           0, 0,             1, 32'h0,        32'h0,        32'h0,        0,  0);
        add(1, 1, 0, 0, 0, 0,           0,           1, 32'h1111_0000, 1, 32'h4,        32'h4,        32'h1111_0000, 1, 0);
        add(1, 1, 0, 0, 0, 0,           0,           1, 32'h1111_0004, 1, 32'h8,        32'h8,        32'h1111_0004, 1, 0);
        add(1, 1, 0, 0, 0, 0,           0,           1, 32'h1111_0008, 1, 32'hC,        32'hC,        32'h1111_0008, 1, 0);
        add(0, 0, 0, 0, 0, 0,           0,           1, 32'h8C01_0004, 0, 32'hC,        32'hC,        32'h1111_0008, 1, 0);
        add(1, 1, 0, 0, 0, 0,           0,           0, 0,             1, 32'h10,       32'h10,       32'h8C01_0004, 1, 0);
        add(1, 1, 0, 0, 0, 0,           0,           0, 0,             1, 32'h10,       32'h10,       32'h0,        0,  1);
        add(1, 1, 1, 1, 0, 32'h40,      0,           0, 0,             1, 32'h10,       32'h10,       32'h0,        0,  0);
        add(1, 1, 0, 0, 0, 0,           0,           0, 0,             1, 32'h10,       32'h10,       32'h0,        0,  1);
        add(1, 1, 0, 0, 0, 0,           0,           1, 32'hDEAD_BEEF, 1, 32'h40,       32'h10,       32'h0,        0,  1);
        add(1, 1, 1, 1, 1, 32'h80,      32'h100,     1, 32'h1111_0040, 1, 32'h80,       32'h10,       32'h0,        0,  0);
        add(1, 1, 0, 0, 0, 0,           0,           0, 0,             1, 32'h80,       32'h10,       32'h0,        0,  1);
        add(1, 1, 0, 0, 0, 0,           0,           1, 32'h1111_0080, 1, 32'h84,       32'h84,       32'h1111_0080, 1, 0);
        add(1, 1, 0, 0, 0, 0,           0,           0, 0,             1, 32'h84,       32'h84,       32'h0,        0,  1);
        add(1, 1, 0, 0, 0, 0,           0,           1, 32'h1111_0084, 1, 32'h88,       32'h88,       32'h1111_0084, 1, 0);
        add(0, 0, 0, 0, 0, 0,           0,           1, 32'h1111_0088, 0, 32'h88,       32'h88,       32'h1111_0084, 1, 0);
        add(0, 0, 0, 0, 0, 0,           0,           1, 32'h0000_0BAD, 0, 32'h88,       32'h88,       32'h1111_0084, 1, 0);
        add(1, 1, 0, 0, 0, 0,           0,           0, 0,             1, 32'h8C,       32'h8C,       32'h1111_0088, 1, 0);
        add(1, 1, 1, 0, 1, 0,           32'hFFFF_FFFC, 1, 32'h1234_5678, 1, 32'hFFFF_FFFC, 32'h8C,     32'h0,        0,  0);
        add(1, 1, 0, 0, 0, 0,           0,           1, 32'h7777_7777, 1, 32'h0,        32'h0,        32'h7777_7777, 1, 0);
        add(0, 1, 0, 1, 0, 32'h200,     0,           1, 32'h5555_5555, 1, 32'h0,        32'h4,        32'h5555_5555, 1, 0);
        add(1, 0, 0, 1, 0, 32'h300,     0,           0, 0,             1, 32'h0,        32'h4,        32'h5555_5555, 1, 0);
        add(1, 0, 0, 0, 1, 0,           32'h400,     0, 0,             1, 32'h0,        32'h4,        32'h5555_5555, 1, 0);
        add(1, 0, 0, 0, 0, 0,           0,           1, 32'h6666_6666, 1, 32'h400,      32'h4,        32'h5555_5555, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pw, tbl[i].iw, tbl[i].fl, tbl[i].ps, tbl[i].jp,
                  tbl[i].br, tbl[i].jt, tbl[i].ack, tbl[i].rdata);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_pc4,
                      tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_busy);
        end

        // Async reset in the middle of a wait, with a valid word in IF/ID.
        drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h9999_9999);
        @(posedge clk);
        @(negedge clk);
        check("pre_reset.if_id_valid", {31'b0, if_id_valid}, 32'h1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.imem_req",    {31'b0, imem_req},    32'h0);
        check("async_rst.if_id_valid", {31'b0, if_id_valid}, 32'h0);
        check("async_rst.imem_addr",   imem_addr,            32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst.imem_req",  {31'b0, imem_req}, 32'h1);
        check("post_rst.imem_addr", imem_addr,         32'h0);

        // Randomized run against the model from a fresh reset.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mem_wait = -1;
        for (int c = 0; c < 3000; c++) begin
            if (m_req()) begin
                if (mem_wait < 0) mem_wait = int'($urandom_range(0, 3));
                if (mem_wait == 0) begin
                    ack = 1'b1; rd = memword(m_pc); mem_wait = -1;
                end else begin
                    ack = 1'b0; rd = $urandom; mem_wait--;
                end
            end else begin
                ack = ($urandom_range(0, 7) == 0);
                rd = $urandom;
            end
            pw = ($urandom_range(0, 3) != 0);
            iw = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 7) == 0);
            ps = ($urandom_range(0, 9) == 0);
            jp = ($urandom_range(0, 9) == 0);
            br = $urandom & 32'hFFFF_FFFC;
            jt = $urandom & 32'hFFFF_FFFC;
            drive(pw, iw, fl, ps, jp, br, jt, ack, rd);
            model_step(pw, iw, fl, ps, jp, br, jt, ack, rd);
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("rand%0d", c), m_req(), m_pc, e_pc4, e_instr, e_valid, e_busy);
        end
`ifdef FETCH_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt, m_bub);
        check("kill_cnt",   kill_cnt,   m_kill);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, the instruction-memory request/acknowledge handshake and the IF/ID pipeline register.
- It is the consumer of the hazard controller's outputs: pc_write, if_id_write, if_id_flush, pc_source, jump.
- It applies stalls, flushes and branch/jump redirects against a variable-latency instruction memory.
- It drives fetch_busy so decode knows a bubble was inserted because of memory latency.

Parameters:
PC_WIDTH, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on bubble or flush

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_write  input  1  hazard ctrl: PC may advance or redirect
if_id_write  input  1  hazard ctrl: IF/ID may load
if_id_flush  input  1  hazard ctrl: force bubble into IF/ID
pc_source  input  1  taken-branch redirect request
branch_target  input  PC_WIDTH  branch destination
jump  input  1  jump redirect request
jump_target  input  PC_WIDTH  jump destination
imem_req  output  1  fetch request
imem_addr  output  PC_WIDTH  fetch address
imem_ack  input  1  read data valid this cycle
imem_rdata  input  32  instruction word
if_id_pc4  output  PC_WIDTH  PC+4 of instruction in IF/ID
if_id_instr  output  32  instruction in IF/ID
if_id_valid  output  1  IF/ID holds a real instruction
fetch_busy  output  1  IF/ID got a memory-latency bubble this cycle (registered)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, fetch_busy=0, kill=0, holding buffer empty. Reset mid-transaction abandons the transaction; the memory must tolerate this.
- States: S_IDLE, S_FETCH, S_HOLD.
- S_IDLE: one cycle, then S_FETCH.
- S_FETCH: imem_req=1; imem_addr=pc, held stable until imem_ack. Ack may arrive the same cycle the request is raised (zero wait). Ack while imem_req=0 is ignored.
- Redirect condition: pc_write=1 and (pc_source or jump). pc_source has priority; target = branch_target if pc_source else jump_target. Redirect with pc_write=0 is ignored.
- S_FETCH, ack, no redirect, kill=0:
  - if_id_write=1: IF/ID <= {pc+4, rdata, valid=1}; if pc_write, pc <= pc+4; stay S_FETCH.
  - if_id_write=0: word stored in holding buffer; pc unchanged; go S_HOLD.
- S_FETCH, ack, kill=1: data discarded; kill <= 0; pc <= saved target; stay S_FETCH (new address from next cycle).
- S_FETCH, no ack, redirect: kill <= 1; saved target <= target. A later redirect overwrites the saved target (latest wins).
- S_FETCH, ack, redirect same cycle: data discarded; pc <= target; kill stays 0.
- S_HOLD: imem_req=0.
  - if_id_write=1: IF/ID loads the buffer; pc <= pc+4 if pc_write; go S_FETCH.
  - Redirect in S_HOLD: buffer dropped; pc <= target; go S_FETCH.
- IF/ID load with no instruction available (S_FETCH, no usable ack, if_id_write=1): bubble {NOP_INSTR, valid=0}; fetch_busy=1 next cycle, otherwise fetch_busy=0.
- if_id_flush=1 overrides everything: IF/ID <= {NOP_INSTR, valid=0} regardless of if_id_write. if_id_pc4 is held. A word captured that cycle is dropped only if a redirect is present; otherwise it goes to the buffer and state S_HOLD.
- if_id_write=0 and no flush: IF/ID holds its value.
- Arithmetic: pc+4 wraps modulo 2^PC_WIDTH. pc[1:0] is not checked.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports bubble_cnt[31:0] and kill_cnt[31:0], both saturating at 32'hFFFF_FFFF and reset to 0.
  - bubble_cnt counts cycles with fetch_busy set.
  - kill_cnt counts acks discarded due to kill or a same-cycle redirect.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package pipeline_pkg: state enum (S_IDLE, S_FETCH, S_HOLD), NOP_INSTR default, PC_INC=4, instruction width 32.
- Sub-module if_id_reg: IF/ID register with write-enable, flush and bubble insertion. Natural because the ID/EX and EX/MEM registers reuse the same pattern.

Test Plan:
- Zero-wait sequential fetch: ack every cycle from RESET_PC=0 -> imem_addr 0,4,8,12 on consecutive cycles; if_id_pc4 4,8,12 with valid=1.
- Load-use stall: pc_write=0, if_id_write=0 for 1 cycle while an ack delivers 0x8C010004 -> S_HOLD, imem_req=0. Next cycle IF/ID loads 0x8C010004 with no re-fetch.
- Branch during outstanding fetch: 3-cycle memory, pc_source=1, branch_target=0x40 at cycle 1 -> IF/ID flushed (valid=0). The ack at cycle 3 is discarded; next imem_addr=0x40.
- Branch and jump together: pc_source=1, jump=1, branch_target=0x80, jump_target=0x100 -> pc=0x80.
- Slow memory: 2-cycle latency with if_id_write=1 -> alternating bubbles, valid=0 and fetch_busy=1 on bubble cycles.
- Async reset at a mid-wait cycle -> imem_req=0 and if_id_valid=0 immediately. After release, the first request is at RESET_PC.
